// File: rtl/led_pkg.sv
// led_pkg -- shared definitions for the LED breathing controller.
//   state_t        : breathing FSM state encoding
//   DUTY_W_DEFAULT : default width of the level / dutycycle paths
package led_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RISE    = 3'd1,
      HOLD_HI = 3'd2,
      FALL    = 3'd3,
      HOLD_LO = 3'd4
   } state_t;

   localparam int DUTY_W_DEFAULT = 11;

endpackage

// File: rtl/led_step_timer.sv
// led_step_timer -- prescaler producing a one-cycle step strobe every
// STEP_CYCLES clocks while run is high. The prescaler is held at zero while
// run is low, so the first strobe after run rises is always STEP_CYCLES away.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   run    : count enable (high while the breather is active)
//   strobe : high for one cycle when the prescaler reaches STEP_CYCLES-1
module led_step_timer #(
   parameter int STEP_CYCLES = 50_000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic strobe
);

   localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign strobe = run && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt <= '0;
      end else if (strobe) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_breathe.sv
// led_breathe -- LED "breathing" envelope generator feeding a PWM block.
// The level ramps up in STEP_INC increments, holds at full scale, ramps down
// to zero, holds, and repeats while en is high. Dropping en fades the LED out
// through FALL rather than cutting it abruptly.
// Optional build macro: LED_BREATHE_GAMMA_EN -- when defined, dutycycle is
// (level*level)>>DUTY_W (square-law curve); otherwise dutycycle = level.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   en        : breathing request
//   dutycycle : registered brightness to the downstream PWM
//   pwm_en    : registered enable to the downstream PWM (state != IDLE, delayed)
//   busy      : high whenever the FSM is not IDLE
module led_breathe
   import led_pkg::*;
#(
   parameter int DUTY_W      = DUTY_W_DEFAULT,
   parameter int STEP_CYCLES = 50_000,
   parameter int STEP_INC    = 8,
   parameter int HOLD_STEPS  = 250
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [DUTY_W-1:0] dutycycle,
   output logic              pwm_en,
   output logic              busy
);

   localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [DUTY_W:0]   LEVEL_MAX = {1'b0, {DUTY_W{1'b1}}};
   localparam logic [DUTY_W:0]   INC_WIDE  = (DUTY_W + 1)'(STEP_INC);
   localparam logic [DUTY_W-1:0] INC       = DUTY_W'(STEP_INC);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

   state_t            state;
   logic [DUTY_W-1:0] level;
   logic [HOLD_W-1:0] hold_cnt;
   logic              en_d;
   logic              strobe;
   logic              step_ok;
   logic [DUTY_W:0]   rise_sum;
   logic              rise_sat;
   logic              fall_sat;
   logic [DUTY_W-1:0] duty_next;

   led_step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .run   (state != IDLE),
      .strobe(strobe)
   );

   // A strobe that lands on the same cycle as an en edge is discarded so the
   // en-driven behaviour wins and the level does not move that cycle.
   assign step_ok  = strobe && (en == en_d);

   // One extra bit lets the rise detect overflow past full scale.
   assign rise_sum = {1'b0, level} + INC_WIDE;
   assign rise_sat = (rise_sum >= LEVEL_MAX);
   assign fall_sat = ({1'b0, level} <= INC_WIDE);

`ifdef LED_BREATHE_GAMMA_EN
   logic [2*DUTY_W-1:0] level_sq;
   assign level_sq  = {{DUTY_W{1'b0}}, level} * {{DUTY_W{1'b0}}, level};
   assign duty_next = DUTY_W'(level_sq >> DUTY_W);
`else
   assign duty_next = level;
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         level     <= '0;
         hold_cnt  <= '0;
         en_d      <= 1'b0;
         dutycycle <= '0;
         pwm_en    <= 1'b0;
      end else begin
         en_d      <= en;
         dutycycle <= duty_next;
         pwm_en    <= (state != IDLE);

         case (state)
            IDLE: begin
               level    <= '0;
               hold_cnt <= '0;
               if (en) state <= RISE;
            end

            RISE: begin
               if (!en) begin
                  state <= FALL;
               end else if (step_ok) begin
                  if (rise_sat) begin
                     level    <= LEVEL_MAX[DUTY_W-1:0];
                     hold_cnt <= '0;
                     state    <= HOLD_HI;
                  end else begin
                     level <= rise_sum[DUTY_W-1:0];
                  end
               end
            end

            HOLD_HI: begin
               if (!en || HOLD_STEPS == 0) begin
                  hold_cnt <= '0;
                  state    <= FALL;
               end else if (step_ok) begin
                  if (hold_cnt == HOLD_LAST) begin
                     hold_cnt <= '0;
                     state    <= FALL;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
            end

            FALL: begin
               // A level already at zero (en dropped before the first rise
               // step) leaves FALL without waiting for a strobe.
               if (level == '0) begin
                  hold_cnt <= '0;
                  state    <= en ? HOLD_LO : IDLE;
               end else if (step_ok) begin
                  if (fall_sat) begin
                     level    <= '0;
                     hold_cnt <= '0;
                     state    <= en ? HOLD_LO : IDLE;
                  end else begin
                     level <= level - INC;
                  end
               end
            end

            HOLD_LO: begin
               if (!en) begin
                  hold_cnt <= '0;
                  state    <= IDLE;
               end else if (HOLD_STEPS == 0) begin
                  hold_cnt <= '0;
                  state    <= RISE;
               end else if (step_ok) begin
                  if (hold_cnt == HOLD_LAST) begin
                     hold_cnt <= '0;
                     state    <= RISE;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
            end

            default: begin
               state <= IDLE;
               level <= '0;
            end
         endcase
      end
   end

endmodule
